dclk_event_bridge: RTL and testbench
====================================

DCLK_EVENT_BRIDGE -- requirements
Module: dclk_event_bridge

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have a parameter FIFO_DEPTH, default 2, giving the number of staging-buffer entries.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on posedge clk.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port dclk, input, 1 bit: divided clock level, generated by a register in the clk domain.
REQ-006 Port fast_valid, input, 1 bit: single-cycle byte strobe from fast logic.
REQ-007 Port fast_data, input, DATA_W bits: payload qualified by fast_valid.
REQ-008 Port slow_valid, output, 1 bit: payload presented to dclk-clocked logic.
REQ-009 Port slow_data, output, DATA_W bits: presented payload.
REQ-010 Port slow_ack, input, 1 bit: consume request from dclk-clocked logic.
REQ-011 Port slow_req, input, 1 bit: event level from dclk-clocked logic.
REQ-012 Port fast_pulse, output, 1 bit: single-clk-cycle event toward fast logic.
REQ-013 Port dclk_rise, output, 1 bit: rising-edge indication of dclk.
REQ-014 Port overflow, output, 1 bit: sticky flag for a dropped payload.

Function
REQ-015 dclk_q SHALL register dclk every cycle.
REQ-016 dclk_rise SHALL equal dclk AND NOT dclk_q (combinational), so it is high for exactly one clk cycle per dclk rising edge.
REQ-017 On fast_valid=1 with the FIFO not full, fast_data SHALL be pushed at that clk edge.
REQ-018 On fast_valid=1 with the FIFO full and no pop in the same cycle, the byte SHALL be dropped and overflow SHALL be set to 1.
REQ-019 overflow SHALL remain set until rst.
REQ-020 A push and a pop in the same cycle on a full FIFO SHALL both take effect; count is unchanged and no overflow is raised.
REQ-021 The output register (slow_valid, slow_data) SHALL update only in cycles where dclk_rise=1, so it is stable for a whole dclk period.
REQ-022 In a dclk_rise cycle, if slow_valid=0 or slow_ack=1: with the FIFO non-empty, the FIFO head SHALL be popped into slow_data and slow_valid set to 1; otherwise slow_valid SHALL be cleared to 0 and slow_data held.
REQ-023 In a dclk_rise cycle, if slow_valid=1 and slow_ack=0, the output register SHALL hold its value.
REQ-024 slow_ack SHALL be ignored outside dclk_rise cycles.
REQ-025 Combined with the output register, total buffering SHALL be FIFO_DEPTH+1 entries.
REQ-026 Latency from fast_valid into an empty bridge to slow_valid=1 SHALL be the cycle after the next dclk_rise; the push cycle's own dclk_rise does not count.
REQ-027 In a dclk_rise cycle, slow_req SHALL be sampled; if it is 1, fast_pulse SHALL be asserted for exactly the following clk cycle.
REQ-028 fast_pulse SHALL assert at most once per dclk period.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL distinguish full from empty.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL clear the FIFO to empty, with slow_valid=0, slow_data=0, fast_pulse=0 and overflow=0.
REQ-031 While rst=1 at a clk edge, dclk_q SHALL be set to 1, so a dclk already high on reset release produces no dclk_rise.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered payloads, with no partial output.
REQ-033 fast_valid and dclk_rise SHALL be ignored while rst=1.

Structure
REQ-034 A shared package SHALL hold DATA_W, FIFO_DEPTH and the pointer-width constant, computed as clog2 of FIFO_DEPTH.
REQ-035 The FIFO SHALL be a sub-module named sync_fifo with ports push, pop, din, dout, full, empty and count.
REQ-036 The bridge shell SHALL hold the edge detector, output register, overflow flag and pulse logic.

Verification
Bench dclk: 5-cycle period, high one cycle (cycle 4, 9, 14, ...).
REQ-037 Reset release with dclk=1 -> dclk_rise=0 in the first cycle; slow_valid=0; overflow=0.
REQ-038 fast_valid with 0xA5 at cycle 6 -> slow_valid=1, slow_data=0xA5 from cycle 10 through at least cycle 14.
REQ-039 Push 0x01, 0x02, 0x03 at cycles 1, 2, 3, with slow_ack held 1 -> slow_data shows 0x01, 0x02, 0x03 on successive dclk periods; then slow_valid=0; overflow=0.
REQ-040 Push 0x10, 0x11, 0x12, 0x13 back-to-back, with slow_ack=0 and the output register already full -> 0x13 is dropped; overflow=1 and it stays 1; later drained sequence is 0x10, 0x11, 0x12.
REQ-041 slow_req=1 held for 12 cycles -> fast_pulse exactly once per dclk_rise (cycles 5, 10), each one cycle wide.
REQ-042 rst=1 for one cycle at cycle 7 with 2 entries buffered -> slow_valid=0 and the FIFO empty at cycle 8; no stale data after the next dclk_rise.

Source files
------------

// File: rtl/dclk_event_bridge_pkg.sv
// Shared sizing constants and helpers for the divided-clock event bridge.
package dclk_event_bridge_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 2;

  // Depth 1 still needs a one-bit pointer so the storage index is never zero-width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PTR_W = ptr_width(FIFO_DEPTH);

endpackage

// File: rtl/dclk_event_bridge_sync_fifo.sv
// Single-clock staging FIFO; pointers wrap at DEPTH, which need not be a power of two.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  import dclk_event_bridge_pkg::*;

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == {CNT_W{1'b0}});
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1'b1);
        2'b01:   count_q <= count_q - CNT_W'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dclk_event_bridge.sv
// Moves single-cycle payload strobes onto a register stable for a whole dclk
// period, and turns a dclk-domain event level into a one-clk pulse.
module dclk_event_bridge #(
  parameter int DATA_W     = dclk_event_bridge_pkg::DATA_W,
  parameter int FIFO_DEPTH = dclk_event_bridge_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dclk,
  input  logic              fast_valid,
  input  logic [DATA_W-1:0] fast_data,
  output logic              slow_valid,
  output logic [DATA_W-1:0] slow_data,
  input  logic              slow_ack,
  input  logic              slow_req,
  output logic              fast_pulse,
  output logic              dclk_rise,
  output logic              overflow
);
  import dclk_event_bridge_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              dclk_q;
  logic              slow_valid_q, slow_valid_d;
  logic [DATA_W-1:0] slow_data_q, slow_data_d;
  logic              overflow_q, overflow_d;
  logic              fast_pulse_q, fast_pulse_d;

  logic              rise_en, out_ready;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_count;

  assign dclk_rise    = dclk & ~dclk_q;
  assign slow_valid   = slow_valid_q;
  assign slow_data    = slow_data_q;
  assign overflow     = overflow_q;
  assign fast_pulse   = fast_pulse_q;
  assign unused_count = ^fifo_count;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fast_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output register and acknowledge are only evaluated on the dclk rising edge.
  always_comb begin
    rise_en      = dclk_rise & ~rst;
    out_ready    = ~slow_valid_q | slow_ack;
    fifo_pop     = rise_en & out_ready & ~fifo_empty;
    fifo_push    = fast_valid & ~rst & (~fifo_full | fifo_pop);
    slow_valid_d = slow_valid_q;
    slow_data_d  = slow_data_q;
    if (rise_en && out_ready) begin
      if (!fifo_empty) begin
        slow_valid_d = 1'b1;
        slow_data_d  = fifo_dout;
      end else begin
        slow_valid_d = 1'b0;
      end
    end else begin
      slow_valid_d = slow_valid_q;
    end
    overflow_d   = overflow_q | (fast_valid & fifo_full & ~fifo_pop);
    fast_pulse_d = rise_en & slow_req;
  end

  // dclk_q resets high so a dclk already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_q       <= 1'b1;
      slow_valid_q <= 1'b0;
      slow_data_q  <= {DATA_W{1'b0}};
      overflow_q   <= 1'b0;
      fast_pulse_q <= 1'b0;
    end else begin
      dclk_q       <= dclk;
      slow_valid_q <= slow_valid_d;
      slow_data_q  <= slow_data_d;
      overflow_q   <= overflow_d;
      fast_pulse_q <= fast_pulse_d;
    end
  end

endmodule

// File: tb/tb_dclk_event_bridge.sv
// Directed bench: cycle 0 is the first cycle after reset release; dclk is high
// in cycles 4, 9, 14, ... (and in cycle 0, to exercise the reset-release case).
module tb_dclk_event_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       dclk;
  logic       fast_valid;
  logic [7:0] fast_data;
  logic       slow_valid;
  logic [7:0] slow_data;
  logic       slow_ack;
  logic       slow_req;
  logic       fast_pulse;
  logic       dclk_rise;
  logic       overflow;

  int cyc;
  int checks;
  int errors;

  always #5 clk = ~clk;

  // Depth 3 lets three payloads wait behind an empty or held output register.
  dclk_event_bridge #(
    .DATA_W     (8),
    .FIFO_DEPTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dclk       (dclk),
    .fast_valid (fast_valid),
    .fast_data  (fast_data),
    .slow_valid (slow_valid),
    .slow_data  (slow_data),
    .slow_ack   (slow_ack),
    .slow_req   (slow_req),
    .fast_pulse (fast_pulse),
    .dclk_rise  (dclk_rise),
    .overflow   (overflow)
  );

  task automatic do_reset();
    rst        = 1'b1;
    dclk       = 1'b1;
    fast_valid = 1'b0;
    fast_data  = 8'h00;
    slow_ack   = 1'b0;
    slow_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    dclk = 1'b1;
    #2;
  endtask

  // Advance to cycle n; inputs change 1 time unit after the edge, checks follow at +3.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc  = cyc + 1;
      dclk = ((cyc % 5) == 4);
      #2;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dclk_rise !== 1'b0) begin errors++; $display("FAIL reset_rise got %b exp 0", dclk_rise); end
    checks++; if (slow_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", slow_valid); end
    checks++; if (slow_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", slow_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (fast_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", fast_pulse); end
    goto(4);
    checks++; if (dclk_rise !== 1'b1) begin errors++; $display("FAIL rise_c4 got %b exp 1", dclk_rise); end
    goto(5);
    checks++; if (dclk_rise !== 1'b0) begin errors++; $display("FAIL rise_c5 got %b exp 0", dclk_rise); end
  endtask

  task automatic test_latency();
    do_reset();
    goto(6);
    fast_valid = 1'b1;
    fast_data  = 8'hA5;
    goto(7);
    fast_valid = 1'b0;
    goto(9);
    checks++; if (slow_valid !== 1'b0) begin errors++; $display("FAIL lat_early c9 got %b exp 0", slow_valid); end
    for (int c = 10; c <= 14; c++) begin
      goto(c);
      checks++;
      if ({slow_valid, slow_data} !== {1'b1, 8'hA5}) begin
        errors++; $display("FAIL lat_hold c%0d got %b/%h exp 1/a5", c, slow_valid, slow_data);
      end
    end
  endtask

  task automatic test_stream();
    int          cyc_t [5];
    logic        vld_t [5];
    logic [7:0]  dat_t [5];
    cyc_t = '{5, 7, 10, 15, 20};
    vld_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dat_t = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h03};
    do_reset();
    slow_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      goto(i);
      fast_valid = 1'b1;
      fast_data  = 8'(i);
    end
    goto(4);
    fast_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      goto(cyc_t[k]);
      checks++;
      if ({slow_valid, slow_data} !== {vld_t[k], dat_t[k]}) begin
        errors++; $display("FAIL stream c%0d got %b/%h exp %b/%h", cyc_t[k], slow_valid, slow_data, vld_t[k], dat_t[k]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    int          cyc_t [4];
    logic        vld_t [4];
    logic [7:0]  dat_t [4];
    cyc_t = '{15, 20, 25, 30};
    vld_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    dat_t = '{8'h10, 8'h11, 8'h12, 8'h12};
    do_reset();
    goto(1);
    fast_valid = 1'b1;
    fast_data  = 8'h55;
    goto(2);
    fast_valid = 1'b0;
    goto(5);
    checks++; if ({slow_valid, slow_data} !== {1'b1, 8'h55}) begin errors++; $display("FAIL ovf_pre got %b/%h exp 1/55", slow_valid, slow_data); end
    for (int i = 0; i < 4; i++) begin
      goto(5 + i);
      fast_valid = 1'b1;
      fast_data  = 8'h10 + 8'(i);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_c8 got %b exp 0", overflow); end
    goto(9);
    fast_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_c9 got %b exp 1", overflow); end
    goto(10);
    checks++; if ({slow_valid, slow_data} !== {1'b1, 8'h55}) begin errors++; $display("FAIL ovf_hold got %b/%h exp 1/55", slow_valid, slow_data); end
    slow_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      goto(cyc_t[k]);
      checks++;
      if ({slow_valid, slow_data} !== {vld_t[k], dat_t[k]}) begin
        errors++; $display("FAIL ovf_drain c%0d got %b/%h exp %b/%h", cyc_t[k], slow_valid, slow_data, vld_t[k], dat_t[k]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int          cyc_t [5];
    logic        vld_t [5];
    logic [7:0]  dat_t [5];
    cyc_t = '{10, 15, 20, 25, 30};
    vld_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dat_t = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h23};
    do_reset();
    goto(1);
    fast_valid = 1'b1;
    fast_data  = 8'h55;
    goto(2);
    fast_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      goto(5 + i);
      fast_valid = 1'b1;
      fast_data  = 8'h20 + 8'(i);
    end
    goto(8);
    fast_valid = 1'b0;
    goto(9);
    // FIFO is full here: push of 0x23 coincides with the pop of 0x20.
    fast_valid = 1'b1;
    fast_data  = 8'h23;
    slow_ack   = 1'b1;
    goto(10);
    fast_valid = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf c10 got %b exp 0", overflow); end
    for (int k = 0; k < 5; k++) begin
      goto(cyc_t[k]);
      checks++;
      if ({slow_valid, slow_data} !== {vld_t[k], dat_t[k]}) begin
        errors++; $display("FAIL b2b_drain c%0d got %b/%h exp %b/%h", cyc_t[k], slow_valid, slow_data, vld_t[k], dat_t[k]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_end got %b exp 0", overflow); end
  endtask

  task automatic test_pulse();
    logic exp_p;
    do_reset();
    slow_req = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      goto(c);
      if (c == 12) slow_req = 1'b0;
      exp_p = (c == 5) || (c == 10);
      checks++;
      if (fast_pulse !== exp_p) begin
        errors++; $display("FAIL pulse c%0d got %b exp %b", c, fast_pulse, exp_p);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    goto(1);
    fast_valid = 1'b1;
    fast_data  = 8'h99;
    goto(2);
    fast_valid = 1'b0;
    goto(5);
    fast_valid = 1'b1;
    fast_data  = 8'h01;
    goto(6);
    fast_data  = 8'h02;
    goto(7);
    fast_data  = 8'h77;
    rst        = 1'b1;
    goto(8);
    rst        = 1'b0;
    fast_valid = 1'b0;
    checks++; if ({slow_valid, slow_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mrst_c8 got %b/%h exp 0/00", slow_valid, slow_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %b exp 0", overflow); end
    goto(10);
    checks++; if ({slow_valid, slow_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mrst_c10 got %b/%h exp 0/00", slow_valid, slow_data); end
    goto(15);
    checks++; if ({slow_valid, slow_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mrst_c15 got %b/%h exp 0/00", slow_valid, slow_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_latency();
    test_stream();
    test_overflow();
    test_back_to_back();
    test_pulse();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
